// File: rtl/matmul_pkg.sv
// Shared defaults, FSM encoding and flat-bus index helpers for the systolic matmul.
package matmul_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 40;
  localparam int SIZE_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_FINISH  = 2'd2
  } state_e;

  // LSB of element (r,c) in a row-major flat bus of size x size elements.
  function automatic int elem_lsb(input int r, input int c, input int size, input int width);
    return (r * size + c) * width;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Output-stationary MAC cell: forwards a east and b south, accumulates a*b.
module systolic_pe #(
  parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = matmul_pkg::ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [ACC_WIDTH-1:0]  acc
);
  localparam int PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [PW-1:0]         a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]  prod_ext;

  // One multiplier serves both modes: the low PW bits of the product of
  // sign-extended operands equal the exact signed product.
  assign a_ext    = {{DATA_WIDTH{signed_mode & a_in[DATA_WIDTH-1]}}, a_in};
  assign b_ext    = {{DATA_WIDTH{signed_mode & b_in[DATA_WIDTH-1]}}, b_in};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_WIDTH-PW){signed_mode & prod[PW-1]}}, prod};

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_ctrl.sv
// N x N matrix multiplier on a SIZE x SIZE systolic grid with skewed injectors.
// state   | meaning
// IDLE    | waiting for start; holds last result
// COMPUTE | t = 0..3N-2: skewed injection plus one flush step
// FINISH  | latch masked accumulators into c_matrix, pulse done
module systolic_matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int SIZE       = SIZE_DEF,
  parameter int N_WIDTH    = $clog2(SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [N_WIDTH-1:0]                n_dim,
  input  logic                              signed_mode,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0]   a_matrix,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0]   b_matrix,
  output logic [SIZE*SIZE*ACC_WIDTH-1:0]    c_matrix,
  output logic                              c_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              err_dim
);
  localparam int T_W = $clog2(3 * SIZE);
  localparam int AW  = SIZE * SIZE * DATA_WIDTH;
  localparam int CW  = SIZE * SIZE * ACC_WIDTH;

  state_e               state_q, state_d;
  logic [T_W-1:0]       t_q, t_d, t_last;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic                 sm_q, sm_d;
  logic [AW-1:0]        a_q, a_d, b_q, b_d;
  logic [CW-1:0]        c_q, c_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d, cv_q, cv_d;
  logic                 accept, n_ok, pe_en;

  logic [DATA_WIDTH-1:0] row_q [SIZE];
  logic [DATA_WIDTH-1:0] row_d [SIZE];
  logic [DATA_WIDTH-1:0] col_q [SIZE];
  logic [DATA_WIDTH-1:0] col_d [SIZE];
  logic [DATA_WIDTH-1:0] a_fwd [SIZE][SIZE];
  logic [DATA_WIDTH-1:0] b_fwd [SIZE][SIZE];
  logic [ACC_WIDTH-1:0]  acc   [SIZE][SIZE];

  assign n_ok   = (n_dim != '0) && (n_dim <= N_WIDTH'(SIZE));
  assign accept = (state_q == ST_IDLE) && start && n_ok;
  assign pe_en  = (state_q == ST_COMPUTE);
  assign t_last = T_W'(n_q) * T_W'(3) - T_W'(2);

  // Row i carries A[i][t-i], column j carries B[t-j][j]; lanes >= N stay 0.
  always_comb begin
    int k;
    k = 0;
    for (int i = 0; i < SIZE; i++) begin
      row_d[i] = '0;
      col_d[i] = '0;
      if (state_q == ST_COMPUTE && i < int'(n_q)) begin
        k = int'(t_q) - i;
        if (k >= 0 && k < int'(n_q)) begin
          row_d[i] = a_q[elem_lsb(i, k, SIZE, DATA_WIDTH) +: DATA_WIDTH];
          col_d[i] = b_q[elem_lsb(k, i, SIZE, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    sm_d    = sm_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    busy_d  = busy_q;
    cv_d    = cv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_COMPUTE;
          t_d     = '0;
          n_d     = n_dim;
          sm_d    = signed_mode;
          a_d     = a_matrix;
          b_d     = b_matrix;
          busy_d  = 1'b1;
          cv_d    = 1'b0;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      ST_COMPUTE: begin
        t_d = t_q + T_W'(1);
        if (t_q == t_last) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cv_d    = 1'b1;
        for (int r = 0; r < SIZE; r++)
          for (int c = 0; c < SIZE; c++)
            c_d[elem_lsb(r, c, SIZE, ACC_WIDTH) +: ACC_WIDTH] =
              (r < int'(n_q) && c < int'(n_q)) ? acc[r][c] : '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      n_q     <= '0;
      sm_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cv_q    <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      sm_q    <= sm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cv_q    <= cv_d;
      for (int i = 0; i < SIZE; i++) begin
        row_q[i] <= row_d[i];
        col_q[i] <= col_d[i];
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in;
      if (j == 0) begin : g_a_edge
        assign a_in = row_q[i];
      end else begin : g_a_int
        assign a_in = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = col_q[j];
      end else begin : g_b_int
        assign b_in = b_fwd[i-1][j];
      end
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .en         (pe_en),
        .signed_mode(sm_q),
        .a_in       (a_in),
        .b_in       (b_in),
        .a_out      (a_fwd[i][j]),
        .b_out      (b_fwd[i][j]),
        .acc        (acc[i][j])
      );
    end
  end

  assign c_matrix = c_q;
  assign c_valid  = cv_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_dim  = err_q;

endmodule

// File: tb/tb_systolic_matmul_ctrl.sv
// Scoreboard bench: accepted jobs push expected C and done cycle; a monitor checks on done.
module tb_systolic_matmul_ctrl;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int SZ = 8;
  localparam int NW = 4;
  localparam int MW = SZ * SZ * DW;
  localparam int CW = SZ * SZ * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] n_dim;
  logic          signed_mode;
  logic [MW-1:0] a_matrix, b_matrix;
  logic [CW-1:0] c_matrix;
  logic          c_valid, busy, done, err_dim;

  systolic_matmul_ctrl #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIZE(SZ), .N_WIDTH(NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_dim      (n_dim),
    .signed_mode(signed_mode),
    .a_matrix   (a_matrix),
    .b_matrix   (b_matrix),
    .c_matrix   (c_matrix),
    .c_valid    (c_valid),
    .busy       (busy),
    .done       (done),
    .err_dim    (err_dim)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    int            lat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MW-1:0] setd(input logic [MW-1:0] m, input int r, input int c,
                                         input logic [DW-1:0] v);
    m[(r*SZ+c)*DW +: DW] = v;
    return m;
  endfunction

  function automatic logic [CW-1:0] setc(input logic [CW-1:0] m, input int r, input int c,
                                         input logic [AW-1:0] v);
    m[(r*SZ+c)*AW +: AW] = v;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_c(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    int bad;
    bad = -1;
    vectors++;
    for (int e = SZ*SZ-1; e >= 0; e--)
      if (act[e*AW +: AW] !== exp[e*AW +: AW]) bad = e;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s: C(%0d,%0d) got %0h, expected %0h", name, bad / SZ, bad % SZ,
               act[bad*AW +: AW], exp[bad*AW +: AW]);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk_c("c_matrix", c_matrix, mon_e.c);
        chk("done_cycle", 64'(cyc), 64'(mon_e.lat));
        chk("c_valid_at_done", 64'(c_valid), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(prev_done), 64'd0);
      end
    end
    prev_done <= done;
  end

  // Caller positions at a negedge; start is held for exactly one clock.
  task automatic issue(input int n, input bit sm, input logic [MW-1:0] a, input logic [MW-1:0] b,
                       input logic [CW-1:0] expc, input bit accepted);
    exp_t e;
    start       = 1'b1;
    n_dim       = n[NW-1:0];
    signed_mode = sm;
    a_matrix    = a;
    b_matrix    = b;
    if (accepted) begin
      e.c   = expc;
      e.lat = cyc + 1 + 3 * n;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (accepted) begin
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("c_valid_drops", 64'(c_valid), 64'd0);
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    int low;
    k   = 0;
    low = 0;
    while (k < 300) begin
      if (done === 1'b1) break;
      if (busy !== 1'b1) low++;
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, 64'(k < 300), 64'd1);
    chk({name, "_busy_throughout"}, 64'(low), 64'd0);
  endtask

  logic [MW-1:0] a1, b1, a2, b2, a3, b3;
  logic [CW-1:0] c1, c2, c3s, c3u, zc;

  initial begin
    a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    c1 = '0; c2 = '0; c3s = '0; c3u = '0; zc = '0;
    a1 = setd(a1, 0, 0, 16'd1); a1 = setd(a1, 0, 1, 16'd2);
    a1 = setd(a1, 1, 0, 16'd3); a1 = setd(a1, 1, 1, 16'd4);
    b1 = setd(b1, 0, 0, 16'd5); b1 = setd(b1, 0, 1, 16'd6);
    b1 = setd(b1, 1, 0, 16'd7); b1 = setd(b1, 1, 1, 16'd8);
    c1 = setc(c1, 0, 0, 40'd19); c1 = setc(c1, 0, 1, 40'd22);
    c1 = setc(c1, 1, 0, 40'd43); c1 = setc(c1, 1, 1, 40'd50);
    for (int r = 0; r < SZ; r++) begin
      a2 = setd(a2, r, r, 16'd1);
      for (int c = 0; c < SZ; c++) begin
        b2  = setd(b2, r, c, 16'(r * 8 + c));
        c2  = setc(c2, r, c, 40'(r * 8 + c));
        a3  = setd(a3, r, c, 16'hFFFF);
        b3  = setd(b3, r, c, 16'd2);
        if (r < 3 && c < 3) begin
          c3s = setc(c3s, r, c, 40'hFF_FFFF_FFFA);
          c3u = setc(c3u, r, c, 40'd393210);
        end
      end
    end

    rst = 1'b0; start = 1'b0; n_dim = '0; signed_mode = 1'b0;
    a_matrix = '0; b_matrix = '0;
    #1;
    chk_c("reset_c_matrix", c_matrix, zc);
    chk("reset_c_valid", 64'(c_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err_dim", 64'(err_dim), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    @(negedge clk); issue(2, 1'b0, a1, b1, c1, 1'b1); wait_done("n2_unsigned");
    @(negedge clk); issue(8, 1'b0, a2, b2, c2, 1'b1); wait_done("n8_identity");
    @(negedge clk); issue(3, 1'b1, a3, b3, c3s, 1'b1); wait_done("n3_signed");

    @(negedge clk); issue(0, 1'b0, a1, b1, zc, 1'b0);
    chk("err_n0_pulse", 64'(err_dim), 64'd1);
    chk("err_n0_busy", 64'(busy), 64'd0);
    chk("err_n0_c_valid", 64'(c_valid), 64'd1);
    chk_c("err_n0_c_kept", c_matrix, c3s);
    @(negedge clk);
    chk("err_n0_one_cycle", 64'(err_dim), 64'd0);
    issue(9, 1'b0, a1, b1, zc, 1'b0);
    chk("err_n9_pulse", 64'(err_dim), 64'd1);
    chk("err_n9_busy", 64'(busy), 64'd0);
    chk_c("err_n9_c_kept", c_matrix, c3s);

    @(negedge clk); issue(3, 1'b0, a3, b3, c3u, 1'b1); wait_done("n3_unsigned");

    @(negedge clk); issue(2, 1'b0, a1, b1, c1, 1'b1);
    @(negedge clk);
    start = 1'b1; n_dim = 4'd3; a_matrix = a3; b_matrix = b3;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored");
    issue(3, 1'b1, a3, b3, c3s, 1'b1);
    wait_done("back_to_back");

    @(negedge clk); issue(8, 1'b0, a2, b2, c2, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    chk_c("midrst_c_matrix", c_matrix, zc);
    chk("midrst_c_valid", 64'(c_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (done === 1'b1) seen++;
      end
      chk("midrst_no_done", 64'(seen), 64'd0);
    end
    issue(2, 1'b0, a1, b1, c1, 1'b1); wait_done("after_reset");

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_ctrl.md
Name: systolic_matmul_ctrl

Overview:
- Self-contained N×N matrix multiplier, C = A·B.
- Runtime dimension N, where 1 ≤ N ≤ SIZE.
- Built on a SIZE×SIZE output-stationary grid of MAC processing elements, fed by skewed row/column injectors.
- Sequenced by a counter-driven FSM with a start/busy/done handshake.
- Parametrised successor to the fixed 6×6 row-broadcast scheduler. Adds:
  - signed/unsigned mode
  - a separate accumulator width
  - dimension error reporting
  - deterministic latency

Parameters:
DATA_WIDTH, 16, width of each A/B element
ACC_WIDTH, 40, width of each accumulator / C element; must be ≥ 2*DATA_WIDTH
SIZE, 8, physical grid dimension (max N)
N_WIDTH, $clog2(SIZE+1), width of the n_dim port

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
n_dim  input  N_WIDTH  active dimension N, captured with start
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
a_matrix  input  SIZE*SIZE*DATA_WIDTH  A row-major, element (r,c) at [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH]
b_matrix  input  SIZE*SIZE*DATA_WIDTH  B, same layout
c_matrix  output  SIZE*SIZE*ACC_WIDTH  C, element (r,c) at [(r*SIZE+c)*ACC_WIDTH +: ACC_WIDTH]
c_valid  output  1  level; high while c_matrix holds a completed result
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse
err_dim  output  1  one-cycle pulse when start is seen with N=0 or N>SIZE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all accumulators, injector registers and counters at 0; c_matrix=0, c_valid=0, busy=0, done=0, err_dim=0. Reset mid-operation abandons the job; no done is issued.
- States: IDLE → COMPUTE → FINISH → IDLE.
- IDLE, start=1, N in range, at edge E0:
  - Capture a_matrix, b_matrix, n_dim and signed_mode into internal registers. Input ports may change afterwards.
  - Clear all accumulators; t=0; busy=1; c_valid=0; go to COMPUTE.
- IDLE, start=1, N out of range: err_dim=1 for one cycle; stay IDLE; c_matrix and c_valid unchanged.
- COMPUTE, injection step t = 0 .. 3N-3:
  - Row injector i presents A[i][t-i] when 0 ≤ t-i < N, else 0.
  - Column injector j presents B[t-j][j] when 0 ≤ t-j < N, else 0.
  - Rows/columns ≥ N inject 0.
- PE(i,j):
  - Registers a eastward and b southward, one cycle per hop.
  - Computes acc += a*b.
  - Product is 2*DATA_WIDTH bits: sign-extended when signed_mode=1, zero-extended otherwise; then extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation.
- COMPUTE timing:
  - Lasts 3N-1 cycles: 3N-2 injection steps plus one pipeline flush.
  - The last product A[N-1][N-1]·B[N-1][N-1] lands in PE(N-1,N-1) on the final COMPUTE edge.
- FINISH, one cycle:
  - c_matrix registered from the accumulators; entries with r ≥ N or c ≥ N are forced to 0.
  - done=1 and c_valid=1 in the cycle after that edge; busy falls with done.
- Latency: done is high in the cycle following edge E0 + 3N. For N=1 that is E0+3; for N=SIZE=8 it is E0+24.
- start while busy: ignored, with no error and no queuing.
- start in the same cycle done is high: state is IDLE, so it is accepted.
- c_matrix holds until the next accepted start; c_valid drops at that start.

Decomposition:
- Package matmul_pkg holds:
  - element/accumulator width defaults
  - FSM state encoding (IDLE, COMPUTE, FINISH)
  - index helper functions for the flat-bus layout
- One sub-module, systolic_pe. It contains:
  - the a/b forwarding registers
  - the MAC with the signed_mode extension
  - a synchronous clear
- The top instantiates the grid via generate, plus the injectors and the FSM.

Test Plan:
- N=2, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C=[[19,22],[43,50]], rest 0. done exactly 6 cycles after the start edge; busy high throughout.
- N=8, A=identity, B(r,c)=r*8+c → C equals B. done at E0+24.
- N=3, signed_mode=1, A all -1 (0xFFFF), B all 2 → every C(r<3, c<3) = -6 sign-extended to 40 bits. Same data with signed_mode=0 → 3*65535*2 = 393210.
- start with n_dim=0, then with n_dim=9 → err_dim pulses once each; busy stays 0; prior c_matrix/c_valid retained.
- start re-asserted mid-COMPUTE with different operands → ignored; result matches the first job. Back-to-back start on the done cycle → second job runs; c_valid drops, then returns.
- rst pulsed low during COMPUTE → all outputs 0 immediately; no done. A fresh job afterwards produces the correct result.
